// File: rtl/mips_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, output register plus
// one-entry skid buffer, and branch/jump redirect with squashing of wrong-path words.
module mips_fetch_stage #(
    parameter logic [31:0] ResetPC = 32'h0000_0000,
    parameter logic [31:0] NopWord = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic        JumpSel,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JumpReg,
    output logic [31:0] Instruction,
    output logic [31:0] NextInstruct,
    output logic        InstValid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_FULL,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_stale;
    logic [31:0] r_instr;
    logic [31:0] r_next;
    logic        r_valid;
    logic [31:0] r_skid;

    logic        w_consume;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_consume  = r_valid && !Stall;
    assign w_redirect = w_consume && (Jump || BranchTaken);
    assign w_pc_plus4 = r_pc + 32'd4;

    // Jump wins over a taken branch; targets are relative to the presented word's PC+4.
    always_comb begin
        w_target = r_next + {BranchOffset[29:0], 2'b00};
        if (Jump) begin
            if (JumpSel) begin
                w_target = {JumpReg[31:2], 2'b00};
            end else begin
                w_target = {r_next[31:28], JumpIndex, 2'b00};
            end
        end
    end

    // DROP keeps presenting the abandoned address until its ack retires it.
    assign imem_req     = !Reset && (r_state != S_FULL);
    assign imem_addr    = (r_state == S_DROP) ? r_stale : r_pc;
    assign Instruction  = r_instr;
    assign NextInstruct = r_next;
    assign InstValid    = r_valid;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
            r_pc    <= ResetPC;
            r_stale <= '0;
            r_instr <= NopWord;
            r_next  <= '0;
            r_valid <= 1'b0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_valid <= 1'b0;
                        r_instr <= NopWord;
                        r_pc    <= w_target;
                        if (!imem_ack) begin
                            r_stale <= r_pc;
                            r_state <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (!r_valid || w_consume) begin
                            r_instr <= imem_rdata;
                            r_next  <= w_pc_plus4;
                            r_valid <= 1'b1;
                        end else begin
                            r_skid  <= imem_rdata;
                            r_state <= S_FULL;
                        end
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                        r_instr <= NopWord;
                    end
                end
                S_FULL: begin
                    if (w_redirect) begin
                        r_valid <= 1'b0;
                        r_instr <= NopWord;
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (w_consume) begin
                        // PC already advanced past the skid word when it was captured.
                        r_instr <= r_skid;
                        r_next  <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Randomized bench for mips_fetch_stage: an architectural program-order model
// predicts each consumed word; a separate monitor pops and compares.
module tb_mips_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'hFFFF_0000;
    localparam int unsigned NCYC   = 3000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchOffset;
    logic        Jump;
    logic        JumpSel;
    logic [25:0] JumpIndex;
    logic [31:0] JumpReg;
    logic [31:0] Instruction;
    logic [31:0] NextInstruct;
    logic        InstValid;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_consumed = 0;
    logic [31:0] exp_q[$];
    logic        phase0;
    int          cyc_since_reset;

    mips_fetch_stage #(.ResetPC(RST_PC), .NopWord(NOP)) dut (
        .Clk(Clk), .Reset(Reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
        .Jump(Jump), .JumpSel(JumpSel), .JumpIndex(JumpIndex), .JumpReg(JumpReg),
        .Instruction(Instruction), .NextInstruct(NextInstruct), .InstValid(InstValid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus, memory model and architectural program-order model.
    initial begin
        logic [31:0] model_pc;
        logic [31:0] n;
        logic        mem_pend;
        logic [31:0] mem_addr;
        int          mem_wait;
        model_pc = RST_PC;
        mem_pend = 1'b0;
        mem_addr = '0;
        mem_wait = 0;
        Reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; Stall = 1'b0;
        BranchTaken = 1'b0; BranchOffset = '0; Jump = 1'b0; JumpSel = 1'b0;
        JumpIndex = '0; JumpReg = '0; phase0 = 1'b1; cyc_since_reset = 0;
        for (int unsigned c = 0; c < NCYC; c++) begin
            @(negedge Clk);
            phase0 = (c < 25);
            Reset  = (c < 2) || (c > 40 && $urandom_range(0, 59) == 0);
            if (phase0) begin
                Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0;
            end else begin
                Stall       = ($urandom_range(0, 9) < 3);
                Jump        = ($urandom_range(0, 9) == 0);
                BranchTaken = ($urandom_range(0, 9) == 0);
            end
            JumpSel      = $urandom_range(0, 1);
            JumpIndex    = 26'($urandom);
            JumpReg      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            BranchOffset = 32'($urandom_range(0, 64)) - 32'd32;
            cyc_since_reset = Reset ? 0 : cyc_since_reset + 1;
            #1;
            if (Reset) begin
                mem_pend   = 1'b0;
                imem_ack   = $urandom_range(0, 1);
                imem_rdata = $urandom;
            end else if (imem_req) begin
                if (!mem_pend) begin
                    mem_pend = 1'b1;
                    mem_addr = imem_addr;
                    mem_wait = phase0 ? 0 : int'($urandom_range(0, 2));
                end else begin
                    chk("addr_stable", imem_addr, mem_addr);
                end
                if (mem_wait == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memf(mem_addr);
                    mem_pend   = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    mem_wait--;
                end
            end else begin
                if (mem_pend) chk("req_held", 32'(imem_req), 32'd1);
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
            end
            if (Reset) begin
                model_pc = RST_PC;
            end else if (InstValid && !Stall) begin
                exp_q.push_back(model_pc);
                n = model_pc + 32'd4;
                if (Jump) begin
                    model_pc = JumpSel ? (JumpReg & ~32'd3) : {n[31:28], JumpIndex, 2'b00};
                end else if (BranchTaken) begin
                    model_pc = n + BranchOffset * 4;
                end else begin
                    model_pc = n;
                end
            end
        end
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        n_cmp++;
        if (n_consumed < 300) begin
            n_bad++;
            $display("FAIL progress: got %0d consumed expected at least 300", n_consumed);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: compares presented words against the model's queue on each consume.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge Clk);
            #2;
            if (Reset) begin
                chk("req_in_reset", 32'(imem_req), 32'd0);
            end else begin
                if (cyc_since_reset == 1) begin
                    chk("rst_valid", 32'(InstValid), 32'd0);
                    chk("rst_instr", Instruction, NOP);
                    chk("rst_next", NextInstruct, 32'd0);
                    chk("rst_req", 32'(imem_req), 32'd1);
                    chk("rst_addr", imem_addr, RST_PC);
                end
                if (phase0) begin
                    chk("seq_addr", imem_addr, RST_PC + 32'(cyc_since_reset - 1) * 32'd4);
                    if (cyc_since_reset >= 2) chk("throughput", 32'(InstValid), 32'd1);
                end
                if (!InstValid) chk("nop_when_invalid", Instruction, NOP);
                if (imem_req) chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (InstValid && !Stall) begin
                    n_consumed++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected none", Instruction);
                    end else begin
                        a = exp_q.pop_front();
                        chk("instr", Instruction, memf(a));
                        chk("next_instr", NextInstruct, a + 32'd4);
                    end
                end
            end
        end
    end

endmodule
